// File: rtl/key_debounce_1khz.sv
// rtl/key_debounce_1khz.sv - synchronised, millisecond-debounced push-button with press/release/repeat pulses
module key_debounce_1khz #(
  parameter int DEBOUNCE_MS     = 20,
  parameter int ACTIVE_LOW      = 1,
  parameter int REPEAT_EN       = 0,
  parameter int REPEAT_DELAY_MS = 500,
  parameter int REPEAT_RATE_MS  = 100
) (
  input  logic f_in,
  input  logic rst,
  input  logic tick_1khz,
  input  logic key_raw,
  output logic key_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse
);

  // Pin level that means "not pressed"; the synchroniser resets to it so no
  // phantom edge is seen when reset is released.
  localparam logic        RELEASED_PIN = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
  localparam logic [7:0]  DB_LAST      = 8'(DEBOUNCE_MS - 1);
  localparam logic [15:0] REP_DELAY    = 16'(REPEAT_DELAY_MS);
  localparam logic [15:0] REP_RATE     = 16'(REPEAT_RATE_MS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESS_WAIT,
    S_HELD,
    S_RELEASE_WAIT
  } state_t;

  logic        r_sync1;
  logic        r_sync2;
  state_t      r_state;
  logic [7:0]  r_db_cnt;
  logic [15:0] r_rep_cnt;
  logic        r_rep_periodic;
  logic        r_key_level;
  logic        r_press;
  logic        r_release;
  logic        r_repeat;

  logic        w_key_s;
  state_t      w_state_nxt;
  logic [7:0]  w_db_nxt;
  logic [15:0] w_rep_nxt;
  logic        w_rep_periodic_nxt;
  logic        w_press_nxt;
  logic        w_release_nxt;
  logic        w_repeat_nxt;
  logic        w_level_nxt;
  logic [15:0] w_rep_limit;
  logic [15:0] w_rep_inc;

  // Two-flop synchroniser on the asynchronous key pin.
  always_ff @(posedge f_in) begin
    if (rst) begin
      r_sync1 <= RELEASED_PIN;
      r_sync2 <= RELEASED_PIN;
    end else begin
      r_sync1 <= key_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Polarity normalised after the synchroniser: 1 = pressed.
  assign w_key_s     = (ACTIVE_LOW != 0) ? ~r_sync2 : r_sync2;
  assign w_rep_limit = r_rep_periodic ? REP_RATE : REP_DELAY;
  assign w_rep_inc   = r_rep_cnt + 16'd1;

  // Next-state, counter and pulse decode; key_s is checked before the tick.
  always_comb begin
    w_state_nxt        = r_state;
    w_db_nxt           = r_db_cnt;
    w_rep_nxt          = r_rep_cnt;
    w_rep_periodic_nxt = r_rep_periodic;
    w_press_nxt        = 1'b0;
    w_release_nxt      = 1'b0;
    w_repeat_nxt       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_key_s) begin
          w_state_nxt = S_PRESS_WAIT;
          w_db_nxt    = 8'd0;
        end
      end
      S_PRESS_WAIT: begin
        if (!w_key_s) begin
          w_state_nxt = S_IDLE;
          w_db_nxt    = 8'd0;
        end else if (tick_1khz) begin
          if (r_db_cnt == DB_LAST) begin
            w_state_nxt        = S_HELD;
            w_db_nxt           = 8'd0;
            w_press_nxt        = 1'b1;
            w_rep_nxt          = 16'd0;
            w_rep_periodic_nxt = 1'b0;
          end else begin
            w_db_nxt = r_db_cnt + 8'd1;
          end
        end
      end
      S_HELD: begin
        if (!w_key_s) begin
          w_state_nxt = S_RELEASE_WAIT;
          w_db_nxt    = 8'd0;
        end else if ((REPEAT_EN != 0) && tick_1khz) begin
          // First pulse after the initial delay, then one per rate interval.
          if (w_rep_inc == w_rep_limit) begin
            w_repeat_nxt       = 1'b1;
            w_rep_nxt          = 16'd0;
            w_rep_periodic_nxt = 1'b1;
          end else begin
            w_rep_nxt = w_rep_inc;
          end
        end
      end
      S_RELEASE_WAIT: begin
        // Bounce back to HELD keeps the repeat counter where it was.
        if (w_key_s) begin
          w_state_nxt = S_HELD;
          w_db_nxt    = 8'd0;
        end else if (tick_1khz) begin
          if (r_db_cnt == DB_LAST) begin
            w_state_nxt   = S_IDLE;
            w_db_nxt      = 8'd0;
            w_release_nxt = 1'b1;
          end else begin
            w_db_nxt = r_db_cnt + 8'd1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_db_nxt    = 8'd0;
      end
    endcase
    w_level_nxt = (w_state_nxt == S_HELD) || (w_state_nxt == S_RELEASE_WAIT);
  end

  // State, counters and registered outputs; reset aborts with no pulse.
  always_ff @(posedge f_in) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_db_cnt       <= 8'd0;
      r_rep_cnt      <= 16'd0;
      r_rep_periodic <= 1'b0;
      r_key_level    <= 1'b0;
      r_press        <= 1'b0;
      r_release      <= 1'b0;
      r_repeat       <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_db_cnt       <= w_db_nxt;
      r_rep_cnt      <= w_rep_nxt;
      r_rep_periodic <= w_rep_periodic_nxt;
      r_key_level    <= w_level_nxt;
      r_press        <= w_press_nxt;
      r_release      <= w_release_nxt;
      r_repeat       <= w_repeat_nxt;
    end
  end

  assign key_level     = r_key_level;
  assign press_pulse   = r_press;
  assign release_pulse = r_release;
  assign repeat_pulse  = r_repeat;

endmodule

// File: tb/tb_key_debounce_1khz.sv
// tb/tb_key_debounce_1khz.sv - self-checking bench for key_debounce_1khz
module tb_key_debounce_1khz;
  localparam int DB    = 4;
  localparam int DELAY = 5;
  localparam int RATE  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick = 1'b0;
  logic key_raw = 1'b1;
  logic lvl0, prs0, rel0, rpt0;
  logic lvl1, prs1, rel1, rpt1;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int seg_press = 0, seg_rel = 0, seg_rpt = 0, seg_rpt0 = 0;

  // reference model state
  logic m_s1 = 1'b1, m_s2 = 1'b1;
  logic m_level = 1'b0;
  logic m_prev_dis = 1'b0;
  int   m_cnt = 0;
  int   m_rep = 0;
  logic m_press = 1'b0, m_rel = 1'b0, m_rpt = 1'b0;

  always #5 clk = ~clk;

  key_debounce_1khz #(.DEBOUNCE_MS(DB), .ACTIVE_LOW(1), .REPEAT_EN(0),
                      .REPEAT_DELAY_MS(DELAY), .REPEAT_RATE_MS(RATE)) u_dut0 (
    .f_in(clk), .rst(rst), .tick_1khz(tick), .key_raw(key_raw),
    .key_level(lvl0), .press_pulse(prs0), .release_pulse(rel0), .repeat_pulse(rpt0)
  );

  key_debounce_1khz #(.DEBOUNCE_MS(DB), .ACTIVE_LOW(1), .REPEAT_EN(1),
                      .REPEAT_DELAY_MS(DELAY), .REPEAT_RATE_MS(RATE)) u_dut1 (
    .f_in(clk), .rst(rst), .tick_1khz(tick), .key_raw(key_raw),
    .key_level(lvl1), .press_pulse(prs1), .release_pulse(rel1), .repeat_pulse(rpt1)
  );

  // Behavioural rule: the accepted level flips once DB ticks have been seen
  // while key_s disagreed with it continuously (the tick of the first
  // disagreeing cycle is not counted). Repeats fire at held-tick DELAY and
  // every RATE ticks after.
  task automatic model_edge(input logic raw, input logic tk, input logic r);
    logic key_s, dis;
    m_press = 1'b0; m_rel = 1'b0; m_rpt = 1'b0;
    if (r) begin
      m_s1 = 1'b1; m_s2 = 1'b1; m_level = 1'b0; m_prev_dis = 1'b0;
      m_cnt = 0; m_rep = 0;
    end else begin
      key_s = ~m_s2;
      dis = (key_s != m_level);
      if (!dis) begin
        m_cnt = 0;
        if (m_level && !m_prev_dis && tk) begin
          m_rep = m_rep + 1;
          if (m_rep == DELAY || (m_rep > DELAY && ((m_rep - DELAY) % RATE) == 0))
            m_rpt = 1'b1;
        end
      end else if (m_prev_dis && tk) begin
        m_cnt = m_cnt + 1;
        if (m_cnt == DB) begin
          m_level = ~m_level;
          m_cnt = 0;
          dis = 1'b0;
          if (m_level) begin m_press = 1'b1; m_rep = 0; end
          else m_rel = 1'b1;
        end
      end
      m_prev_dis = dis;
      m_s2 = m_s1;
      m_s1 = raw;
    end
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s obs=%0d exp=%0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step(input logic raw, input logic tk, input logic r);
    @(negedge clk);
    key_raw = raw; tick = tk; rst = r;
    @(posedge clk);
    model_edge(raw, tk, r);
    #1;
    chk("level0", int'(lvl0), int'(m_level));
    chk("press0", int'(prs0), int'(m_press));
    chk("release0", int'(rel0), int'(m_rel));
    chk("repeat0", int'(rpt0), 0);
    chk("level1", int'(lvl1), int'(m_level));
    chk("press1", int'(prs1), int'(m_press));
    chk("release1", int'(rel1), int'(m_rel));
    chk("repeat1", int'(rpt1), int'(m_rpt));
    if (prs1) seg_press++;
    if (rel1) seg_rel++;
    if (rpt1) seg_rpt++;
    if (rpt0) seg_rpt0++;
    cyc++;
  endtask

  task automatic run(input logic raw, input int n);
    for (int k = 0; k < n; k++) step(raw, (cyc % 10) == 9, 1'b0);
  endtask

  task automatic clr();
    seg_press = 0; seg_rel = 0; seg_rpt = 0; seg_rpt0 = 0;
  endtask

  initial begin
    logic raw_r;
    logic got;
    int   mode;
    logic tk;

    // reset state
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    chk("rst_level", int'(lvl1), 0);
    run(1'b1, 8);

    // clean press
    clr();
    run(1'b0, 60);
    chk("press_count", seg_press, 1);
    chk("press_level", int'(lvl1), 1);

    // release with a glitch back to pressed, then a clean release
    clr();
    run(1'b1, 15);
    run(1'b0, 12);
    chk("glitch_release_count", seg_rel, 0);
    chk("glitch_level", int'(lvl1), 1);
    clr();
    run(1'b1, 60);
    chk("release_count", seg_rel, 1);
    chk("release_level", int'(lvl1), 0);

    // bounce: never stable for DB ticks
    clr();
    for (int k = 0; k < 60; k++) step(((k / 7) % 2) == 0 ? 1'b0 : 1'b1, (cyc % 10) == 9, 1'b0);
    run(1'b1, 30);
    chk("bounce_press_count", seg_press, 0);
    chk("bounce_level", int'(lvl1), 0);

    // key_s falls in the same cycle as the DB-th tick
    clr();
    step(1'b0, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin step(1'b0, 1'b1, 1'b0); step(1'b0, 1'b0, 1'b0); end
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    run(1'b1, 20);
    chk("samecycle_press_count", seg_press, 0);
    chk("samecycle_level", int'(lvl1), 0);

    // auto-repeat: hold for 9 ticks after press
    clr();
    got = 1'b0;
    for (int k = 0; k < 100 && !got; k++) begin
      step(1'b0, (cyc % 10) == 9, 1'b0);
      got = prs1;
    end
    chk("repeat_press_seen", int'(got), 1);
    clr();
    run(1'b0, 95);
    run(1'b1, 60);
    chk("repeat_count", seg_rpt, 3);
    chk("repeat_count_disabled", seg_rpt0, 0);
    chk("repeat_release_count", seg_rel, 1);

    // reset in PRESS_WAIT with db_cnt=3, then a fresh full debounce
    run(1'b1, 10);
    step(1'b0, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin step(1'b0, 1'b1, 1'b0); step(1'b0, 1'b0, 1'b0); end
    step(1'b0, 1'b0, 1'b1);
    chk("rst_mid_level", int'(lvl1), 0);
    chk("rst_mid_press", int'(prs1), 0);
    chk("rst_mid_release", int'(rel1), 0);
    chk("rst_mid_repeat", int'(rpt1), 0);
    clr();
    step(1'b0, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin step(1'b0, 1'b1, 1'b0); step(1'b0, 1'b0, 1'b0); end
    chk("rst_three_ticks_press", seg_press, 0);
    step(1'b0, 1'b1, 1'b0);
    chk("rst_fourth_tick_press", int'(prs1), 1);
    run(1'b1, 60);

    // tick stuck high: counts once per cycle
    clr();
    for (int k = 0; k < 10; k++) step(1'b0, 1'b1, 1'b0);
    chk("stuck_tick_press", seg_press, 1);
    for (int k = 0; k < 10; k++) step(1'b1, 1'b1, 1'b0);
    chk("stuck_tick_release", seg_rel, 1);

    // randomized stimulus against the model
    raw_r = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 24) == 0) raw_r = ~raw_r;
      mode = (i < 2400) ? ((i / 600) % 2) : 2;
      if (mode == 0) tk = ((cyc % 10) == 9);
      else if (mode == 1) tk = ($urandom_range(0, 3) == 0);
      else tk = 1'b1;
      step(raw_r, tk, $urandom_range(0, 399) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
